// File: rtl/acc_arb_pkg.sv
// Shared types and helpers for the accelerator request arbiter.
// Covers the counter type, the error-cause encoding and the index arithmetic.
package acc_arb_pkg;

  localparam int unsigned DefaultMaxOutstanding = 4;
  localparam int unsigned DefaultCntWidth       = $clog2(DefaultMaxOutstanding + 1);

  typedef logic [DefaultCntWidth-1:0] cnt_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_BAD_ID,
    ERR_UNDERFLOW
  } err_cause_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(int unsigned ptr, int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/acc_outstanding_cnt.sv
// Saturating up/down counter tracking in-flight requests of one master.
// Simultaneous inc and dec leave the count unchanged.
module acc_outstanding_cnt #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                underflow_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign full_o      = (cnt_q == CntMax);
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator port among NumReq masters,
// tagging requests with the master index and routing responses back by ID.
module acc_req_arbiter
  import acc_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = idx_width(NumReq),
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 mst_q_valid_i,
  output logic [NumReq-1:0]                 mst_q_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0]  mst_q_data_i,
  output logic [NumReq-1:0]                 mst_p_valid_o,
  input  logic [NumReq-1:0]                 mst_p_ready_i,
  output logic [DataWidth-1:0]              mst_p_data_o,
  output logic                              slv_q_valid_o,
  input  logic                              slv_q_ready_i,
  output logic [DataWidth-1:0]              slv_q_data_o,
  output logic [IdWidth-1:0]                slv_q_id_o,
  input  logic                              slv_p_valid_i,
  output logic                              slv_p_ready_o,
  input  logic [DataWidth-1:0]              slv_p_data_i,
  input  logic [IdWidth-1:0]                slv_p_id_i,
  output logic                              busy_o,
  output logic                              err_o
);

  logic                              out_en_q;
  logic                              lock_q, lock_d;
  logic [IdWidth-1:0]                gnt_q, gnt, gnt_arb;
  logic [IdWidth-1:0]                ptr_q, ptr_d;
  logic                              busy_q;
  err_cause_e                        err_cause_q, err_cause_d;
  logic                              arb_found, q_hs, p_hs, id_ok;
  logic [NumReq-1:0]                 elig, full, underflow, inc, dec, nz_next;
  logic [NumReq-1:0][CntWidth-1:0]   cnt;

  for (genvar i = 0; i < NumReq; i++) begin : g_cnt
    acc_outstanding_cnt #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (inc[i]),
      .dec_i       (dec[i]),
      .count_o     (cnt[i]),
      .full_o      (full[i]),
      .underflow_o (underflow[i])
    );

    assign elig[i] = mst_q_valid_i[i] && !full[i];
    // Predicts whether this counter is nonzero after the edge, so busy_o can be registered.
    assign nz_next[i] = (inc[i] && !dec[i]) ? 1'b1 :
                        (dec[i] && !inc[i]) ? (cnt[i] > CntWidth'(1)) :
                                              (cnt[i] != '0);
  end

  // Two passes: indices at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_arb   = '0;
    arb_found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!arb_found && elig[i] && (i >= 32'(ptr_q))) begin
        arb_found = 1'b1;
        gnt_arb   = IdWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!arb_found && elig[i] && (i < 32'(ptr_q))) begin
        arb_found = 1'b1;
        gnt_arb   = IdWidth'(i);
      end
    end
  end

  assign gnt           = lock_q ? gnt_q : gnt_arb;
  assign slv_q_valid_o = out_en_q && (lock_q || arb_found);
  assign slv_q_id_o    = gnt;
  assign q_hs          = slv_q_valid_o && slv_q_ready_i;
  assign lock_d        = slv_q_valid_o && !slv_q_ready_i;
  assign ptr_d         = q_hs ? IdWidth'(rr_next(32'(gnt), NumReq)) : ptr_q;

  always_comb begin
    slv_q_data_o  = '0;
    mst_q_ready_o = '0;
    inc           = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (gnt == IdWidth'(i)) begin
        slv_q_data_o     = mst_q_data_i[i];
        mst_q_ready_o[i] = slv_q_ready_i && slv_q_valid_o;
        inc[i]           = q_hs;
      end
    end
  end

  // Unknown IDs are sunk so a stray response can never stall the accelerator.
  always_comb begin
    mst_p_valid_o = '0;
    slv_p_ready_o = 1'b0;
    id_ok         = 1'b0;
    dec           = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (slv_p_id_i == IdWidth'(i)) begin
        id_ok            = 1'b1;
        mst_p_valid_o[i] = out_en_q && slv_p_valid_i;
        slv_p_ready_o    = out_en_q && mst_p_ready_i[i];
        dec[i]           = out_en_q && slv_p_valid_i && mst_p_ready_i[i];
      end
    end
    if (!id_ok) begin
      slv_p_ready_o = out_en_q;
    end
  end

  assign p_hs         = slv_p_valid_i && slv_p_ready_o;
  assign mst_p_data_o = slv_p_data_i;

  always_comb begin
    err_cause_d = ERR_NONE;
    if (p_hs && !id_ok) begin
      err_cause_d = ERR_BAD_ID;
    end else if (|underflow) begin
      err_cause_d = ERR_UNDERFLOW;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_en_q    <= 1'b0;
      lock_q      <= 1'b0;
      gnt_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      err_cause_q <= ERR_NONE;
    end else begin
      out_en_q    <= 1'b1;
      lock_q      <= lock_d;
      gnt_q       <= gnt;
      ptr_q       <= ptr_d;
      busy_q      <= |nz_next;
      err_cause_q <= err_cause_d;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = (err_cause_q != ERR_NONE);

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: a vector table for streaming/throttling
// plus hand sequences for stalls, routing, inc/dec collisions, errors and reset.
module tb_acc_req_arbiter;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [7:0]        mqv, mqr, mpv, mpr;
  logic [7:0][31:0]  mqd;
  logic [31:0]       mpd, sqd, spd;
  logic              sqv, sqr, spv, spr, busy, err;
  logic [2:0]        sqid, spid;

  logic [4:0]        mqv5, mqr5, mpv5, mpr5;
  logic [4:0][31:0]  mqd5;
  logic [31:0]       mpd5, sqd5, spd5;
  logic              sqv5, sqr5, spv5, spr5, busy5, err5;
  logic [2:0]        sqid5, spid5;

  int checks = 0;
  int errors = 0;

  acc_req_arbiter #(.NumReq(8), .DataWidth(32), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mst_q_valid_i(mqv), .mst_q_ready_o(mqr), .mst_q_data_i(mqd),
    .mst_p_valid_o(mpv), .mst_p_ready_i(mpr), .mst_p_data_o(mpd),
    .slv_q_valid_o(sqv), .slv_q_ready_i(sqr), .slv_q_data_o(sqd), .slv_q_id_o(sqid),
    .slv_p_valid_i(spv), .slv_p_ready_o(spr), .slv_p_data_i(spd), .slv_p_id_i(spid),
    .busy_o(busy), .err_o(err)
  );

  acc_req_arbiter #(.NumReq(5), .DataWidth(32), .MaxOutstanding(4)) dut5 (
    .clk_i(clk), .rst_ni(rst_ni),
    .mst_q_valid_i(mqv5), .mst_q_ready_o(mqr5), .mst_q_data_i(mqd5),
    .mst_p_valid_o(mpv5), .mst_p_ready_i(mpr5), .mst_p_data_o(mpd5),
    .slv_q_valid_o(sqv5), .slv_q_ready_i(sqr5), .slv_q_data_o(sqd5), .slv_q_id_o(sqid5),
    .slv_p_valid_i(spv5), .slv_p_ready_o(spr5), .slv_p_data_i(spd5), .slv_p_id_i(spid5),
    .busy_o(busy5), .err_o(err5)
  );

  typedef struct {
    logic [7:0] qv;
    logic       sr;
    logic       pv;
    logic [2:0] pid;
    logic [7:0] emqr;
    logic       eqv;
    logic [2:0] eid;
    logic [7:0] epv;
    logic       ebusy;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    mqv = '0; sqr = 1'b1; spv = 1'b0; spid = '0; mpr = 8'hFF; spd = '0;
    mqv5 = '0; sqr5 = 1'b1; spv5 = 1'b0; spid5 = '0; mpr5 = 5'h1F; spd5 = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mqd[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 5; i++) mqd5[i] = 32'hB000_0000 + i;
    idle();
    rst_ni = 1'b0;
    mqv = 8'hFF; spv = 1'b1;

    // Outputs gated while reset is held, even with live inputs.
    #12;
    chk("rst_sqv", sqv, 0);
    chk("rst_mqr", mqr, 0);
    chk("rst_mpv", mpv, 0);
    chk("rst_spr", spr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // Streaming masters 0 and 3, each throttled at four outstanding.
    vecs.push_back('{8'h09, 1, 0, 0, 8'h01, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h08, 1, 3, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h01, 1, 0, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h08, 1, 3, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h01, 1, 0, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h08, 1, 3, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h01, 1, 0, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h08, 1, 3, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 1, 3, 8'h00, 0, 0, 8'h08, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h08, 1, 3, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0});
    vecs.push_back('{8'h09, 1, 1, 0, 8'h00, 0, 0, 8'h01, 1, 0});
    vecs.push_back('{8'h09, 1, 0, 0, 8'h01, 1, 0, 8'h00, 1, 0});

    do_reset();
    foreach (vecs[k]) begin
      mqv = vecs[k].qv; sqr = vecs[k].sr; spv = vecs[k].pv; spid = vecs[k].pid;
      smp();
      chk($sformatf("v%0d_sqv", k), sqv, vecs[k].eqv);
      chk($sformatf("v%0d_mqr", k), mqr, vecs[k].emqr);
      if (vecs[k].eqv) begin
        chk($sformatf("v%0d_id", k), sqid, vecs[k].eid);
        chk($sformatf("v%0d_data", k), sqd, 32'hA000_0000 + vecs[k].eid);
      end
      chk($sformatf("v%0d_mpv", k), mpv, vecs[k].epv);
      chk($sformatf("v%0d_spr", k), spr, 1);
      chk($sformatf("v%0d_busy", k), busy, vecs[k].ebusy);
      chk($sformatf("v%0d_err", k), err, vecs[k].eerr);
      nxt();
    end

    // Backpressure: grant to 1 held for five stalled cycles, then 2, 5, wrap to 6.
    do_reset();
    mqv = 8'h26; sqr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("bp_sqv", sqv, 1);
      chk("bp_id", sqid, 1);
      chk("bp_data", sqd, 32'hA000_0001);
      chk("bp_mqr", mqr, 0);
      nxt();
    end
    sqr = 1'b1;
    smp(); chk("bp_rel_id1", sqid, 1); chk("bp_rel_mqr1", mqr, 8'h02); nxt();
    smp(); chk("bp_rel_id2", sqid, 2); chk("bp_rel_mqr2", mqr, 8'h04); nxt();
    smp(); chk("bp_rel_id5", sqid, 5); chk("bp_rel_mqr5", mqr, 8'h20); nxt();
    mqv = 8'h41;
    smp(); chk("bp_wrap_id6", sqid, 6); nxt();

    // Response routing to master 5 with a 3-cycle master stall.
    do_reset();
    mqv = 8'h20;
    smp(); chk("rt_req_a", sqid, 5); nxt();
    smp(); chk("rt_req_b", sqid, 5); nxt();
    mqv = '0;
    spv = 1'b1; spid = 3'd5; spd = 32'hDEAD_BEEF; mpr = 8'hDF;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rt_mpv", mpv, 8'h20);
      chk("rt_spr", spr, 0);
      chk("rt_data", mpd, 32'hDEAD_BEEF);
      chk("rt_busy", busy, 1);
      nxt();
    end
    mpr = 8'hFF;
    smp(); chk("rt_spr_up", spr, 1); nxt();
    spv = 1'b0;
    smp(); chk("rt_busy_one_left", busy, 1); chk("rt_err_a", err, 0); nxt();
    spv = 1'b1;
    smp(); chk("rt_spr_second", spr, 1); nxt();
    spv = 1'b0;
    smp(); chk("rt_busy_drained", busy, 0); chk("rt_err_b", err, 0); nxt();

    // Request and response on master 2 in the same cycle with cnt=2.
    do_reset();
    mqv = 8'h04;
    smp(); chk("id_req_a", sqid, 2); nxt();
    smp(); chk("id_req_b", sqid, 2); nxt();
    spv = 1'b1; spid = 3'd2;
    smp();
    chk("id_both_sqv", sqv, 1);
    chk("id_both_id", sqid, 2);
    chk("id_both_mpv", mpv, 8'h04);
    chk("id_both_spr", spr, 1);
    nxt();
    mqv = '0; spv = 1'b0;
    smp(); chk("id_busy", busy, 1); chk("id_err", err, 0); nxt();
    mqv = 8'h04;
    smp(); chk("id_room_a", sqv, 1); nxt();
    smp(); chk("id_room_b", sqv, 1); nxt();
    smp(); chk("id_capped", sqv, 0); nxt();
    mqv = '0;

    // Response to an idle master: delivered, error pulse, counter stays at zero.
    do_reset();
    spv = 1'b1; spid = 3'd0;
    smp(); chk("uf_mpv", mpv, 8'h01); chk("uf_spr", spr, 1); nxt();
    spv = 1'b0;
    smp(); chk("uf_err", err, 1); chk("uf_busy", busy, 0); nxt();
    smp(); chk("uf_err_clear", err, 0); nxt();
    mqv = 8'h01;
    for (int c = 0; c < 4; c++) begin
      smp(); chk("uf_grant", sqv, 1); nxt();
    end
    smp(); chk("uf_fifth_blocked", sqv, 0); nxt();
    mqv = '0;

    // Out-of-range response ID on a five-master arbiter.
    spv5 = 1'b1; spid5 = 3'd7; mpr5 = 5'h00;
    smp(); chk("bad_spr", spr5, 1); chk("bad_mpv", mpv5, 0); nxt();
    spv5 = 1'b0;
    smp(); chk("bad_err", err5, 1); nxt();
    smp(); chk("bad_err_clear", err5, 0); nxt();
    mqv5 = 5'h10;
    smp(); chk("n5_grant_id", sqid5, 4); chk("n5_data", sqd5, 32'hB000_0004); nxt();
    mqv5 = '0;

    // Asynchronous reset while locked with cnt[4]=3.
    do_reset();
    mqv = 8'h10;
    for (int c = 0; c < 3; c++) begin
      smp(); chk("mr_fill", sqid, 4); nxt();
    end
    sqr = 1'b0;
    smp(); chk("mr_stall", sqv, 1); nxt();
    smp(); chk("mr_locked", sqv, 1);
    sqr = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_sqv", sqv, 0);
    chk("mr_mqr", mqr, 0);
    chk("mr_spr", spr, 0);
    chk("mr_busy", busy, 0);
    mqv = 8'h24;
    @(posedge clk);
    #2 rst_ni = 1'b1;
    nxt();
    smp(); chk("mr_first_id", sqid, 2); chk("mr_first_busy", busy, 0); nxt();
    mqv = 8'h10;
    for (int c = 0; c < 4; c++) begin
      smp(); chk("mr_refill", sqv, 1); nxt();
    end
    smp(); chk("mr_cap", sqv, 0); nxt();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_req_arbiter.md
Name: acc_req_arbiter

Overview:
- Shares one accelerator slave port among NumReq requesting cores.
- Round-robin arbitration on the request channel; the granted requester index is appended as the transaction ID.
- Responses are routed back by ID.
- Per-requester outstanding-transaction counters throttle each core to MaxOutstanding in-flight requests.
- Sits in front of a single accelerator, one level below the acc interconnect crossbar.

Parameters:
- NumReq, 8, number of requesting masters (≥1).
- DataWidth, 32, request/response payload width.
- MaxOutstanding, 4, max in-flight requests per master (≥1).
- IdWidth, cf_math_pkg::idx_width(NumReq), derived; width of slv_q_id_o / slv_p_id_i.
- CntWidth, $clog2(MaxOutstanding+1), derived; counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mst_q_valid_i  in  NumReq  per-master request valid.
- mst_q_ready_o  out  NumReq  per-master request ready.
- mst_q_data_i  in  NumReq×DataWidth  per-master request payload.
- mst_p_valid_o  out  NumReq  per-master response valid.
- mst_p_ready_i  in  NumReq  per-master response ready.
- mst_p_data_o  out  DataWidth  response payload, broadcast to all masters.
- slv_q_valid_o  out  1  request valid to accelerator.
- slv_q_ready_i  in  1  accelerator request ready.
- slv_q_data_o  out  DataWidth  granted payload.
- slv_q_id_o  out  IdWidth  granted master index.
- slv_p_valid_i  in  1  accelerator response valid.
- slv_p_ready_o  out  1  response ready to accelerator.
- slv_p_data_i  in  DataWidth  response payload.
- slv_p_id_i  in  IdWidth  response destination ID.
- busy_o  out  1  any counter nonzero (registered).
- err_o  out  1  one-cycle pulse on protocol error (registered).

Behaviour:
- Reset (async, rst_ni=0):
  - All counters = 0, RR pointer = 0, lock = 0.
  - busy_o = 0, err_o = 0.
  - All valid/ready outputs 0 while in reset (gated with a registered reset flag).
- Eligibility: master i is eligible iff mst_q_valid_i[i] && cnt[i] < MaxOutstanding.
- Arbitration (unlocked):
  - Grant the first eligible index scanning from pointer upward, wrapping at NumReq.
  - Combinational; zero-cycle latency from master valid to slv_q_valid_o.
- Stability:
  - If slv_q_valid_o=1 and slv_q_ready_i=0, set lock and hold the grant index in a register.
  - While locked, slv_q_valid_o, slv_q_data_o and slv_q_id_o stay stable. Masters must not drop valid; the grant holds even if the counter condition changes.
  - Lock clears on handshake.
- Request handshake: slv_q_valid_o && slv_q_ready_i.
  - mst_q_ready_o[g] = slv_q_ready_i for the granted g; all others 0.
  - On handshake, pointer ← (g+1) mod NumReq and cnt[g] increments.
- Response routing, when slv_p_id_i < NumReq:
  - mst_p_valid_o[id] = slv_p_valid_i; all others 0.
  - slv_p_ready_o = mst_p_ready_i[id].
  - A response handshake decrements cnt[id].
- Invalid response ID (slv_p_id_i ≥ NumReq): slv_p_ready_o=1, response dropped, err_o pulses next cycle.
- Response to a master with cnt=0: delivered normally, counter saturates at 0, err_o pulses next cycle.
- Simultaneous increment and decrement on the same counter in one cycle: count unchanged.
- Counter never exceeds MaxOutstanding, because the eligibility gate prevents it.
- Reset mid-transaction: counters and lock drop immediately; in-flight accelerator responses after reset are handled as errors per the rules above.
- busy_o registered: OR of (cnt≠0) of next-state counters.
- No combinational path from mst_q_valid_i to mst_q_ready_o other than through grant selection. slv_q_ready_i→mst_q_ready_o is combinational.

Decomposition:
- Package acc_arb_pkg:
  - cnt_t sized by CntWidth.
  - Function rr_next(ptr, NumReq).
  - Error-cause enum {ERR_NONE, ERR_BAD_ID, ERR_UNDERFLOW} (internal; debug visibility).
- One sub-module acc_outstanding_cnt, instantiated NumReq times:
  - Inputs: inc, dec. Outputs: count, full, underflow.
  - Saturating up/down counter with async active-low reset.
- Arbiter core (pointer, lock, grant mux) and response demux live in the top module.

Test Plan:
- Two masters streaming, slave always ready:
  - NumReq=8; masters 0 and 3 continuously valid.
  - slv_q_id_o alternates 0,3,0,3.
  - Each cnt reaches MaxOutstanding=4 and no fifth grant occurs until a response with that ID is returned.
- Backpressure stability:
  - Masters 1,2,5 valid; slv_q_ready_i=0 for 5 cycles.
  - slv_q_id_o=1 and data constant all 5 cycles.
  - On ready, grant moves to 2 then 5; pointer wraps to 6.
- Response routing:
  - Inject slv_p_valid_i with id=5, data=0xDEADBEEF while mst_p_ready_i[5]=0 for 3 cycles.
  - Only mst_p_valid_o[5]=1 and slv_p_ready_o=0 for 3 cycles.
  - After ready rises, cnt[5] decrements by 1.
- Simultaneous inc/dec:
  - Master 2 with cnt=2 gets a request handshake and a response handshake in the same cycle.
  - cnt[2] stays 2; busy_o remains 1.
- Errors:
  - NumReq=5, response id=7 → slv_p_ready_o=1, no mst_p_valid_o asserted, err_o=1 for exactly one cycle.
  - Response id=0 with cnt[0]=0 → delivered to master 0, err_o pulse, cnt[0] stays 0.
- Reset mid-operation:
  - Assert rst_ni=0 asynchronously mid-cycle while locked with cnt[4]=3.
  - All outputs go 0 immediately; after release, cnt=0 and pointer=0.
  - First grant goes to the lowest valid index.
